// File: rtl/uart_tx.sv
// uart_tx: 2-bit UART frame transmitter.
// Frame: start(0), d[1], d[0], parity, guard(1), stop(1); each bit lasts
// CLKS_PER_BIT rxclk cycles. tx_out and tx_busy come straight from flops.
module uart_tx #(
   parameter int CLKS_PER_BIT = 8,
   parameter bit PARITY_ODD   = 1'b0
) (
   input  logic       rxclk,
   input  logic       reset,
   input  logic [1:0] tx_data,
   input  logic       ld_tx_data,
   input  logic       tx_enable,
   output logic       tx_out,
   output logic       tx_busy,
   output logic       tx_over_run
);

   localparam int            TW        = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_GUARD,
      S_STOP
   } state_t;

   state_t        r_state,    w_state;
   logic [TW-1:0] r_tick,     w_tick;
   logic          r_bit_idx,  w_bit_idx;
   logic [1:0]    r_data,     w_data;
   logic          r_parity,   w_parity;
   logic          r_tx_out,   w_tx_out;
   logic          r_busy,     w_busy;
   logic          r_over_run, w_over_run;
   logic          w_tick_done;

   assign w_tick_done = (r_tick == TICK_LAST);

   assign tx_out      = r_tx_out;
   assign tx_busy     = r_busy;
   assign tx_over_run = r_over_run;

   // State and datapath registers; asynchronous reset forces an idle line.
   // NOTE: the holding register and parity are reset too, so a frame can
   // never be launched from an unknown word after power-up.
   always_ff @(posedge rxclk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_tick     <= '0;
         r_bit_idx  <= 1'b0;
         r_data     <= 2'b00;
         r_parity   <= 1'b0;
         r_tx_out   <= 1'b1;
         r_busy     <= 1'b0;
         r_over_run <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // values computed for this edge, independent of statement order.
         r_state    <= w_state;
         r_tick     <= w_tick;
         r_bit_idx  <= w_bit_idx;
         r_data     <= w_data;
         r_parity   <= w_parity;
         r_tx_out   <= w_tx_out;
         r_busy     <= w_busy;
         r_over_run <= w_over_run;
      end
   end

   // Next-state, next line level and flag logic for the frame sequencer.
   always_comb begin
      // NOTE: every output of this block gets a default first; a path that
      // skips an assignment would otherwise infer a latch.
      w_state    = r_state;
      w_tick     = r_tick;
      w_bit_idx  = r_bit_idx;
      w_data     = r_data;
      w_parity   = r_parity;
      w_tx_out   = r_tx_out;
      w_busy     = r_busy;
      w_over_run = r_over_run;

      // A load seen while a frame is in flight (including the edge where
      // busy drops) is dropped and remembered as an overrun.
      if (ld_tx_data && r_busy) begin
         w_over_run = 1'b1;
      end

      case (r_state)
         S_IDLE: begin
            w_tick    = '0;
            w_bit_idx = 1'b0;
            if (ld_tx_data && tx_enable) begin
               w_state    = S_START;
               w_data     = tx_data;
               w_parity   = (^tx_data) ^ PARITY_ODD;
               w_over_run = 1'b0;
               w_busy     = 1'b1;
               w_tx_out   = 1'b0;
            end
         end
         default: begin
            if (w_tick_done) begin
               w_tick = '0;
               case (r_state)
                  S_START: begin
                     w_state  = S_DATA;
                     w_tx_out = r_data[1];
                  end
                  S_DATA: begin
                     if (!r_bit_idx) begin
                        w_bit_idx = 1'b1;
                        w_tx_out  = r_data[0];
                     end else begin
                        w_bit_idx = 1'b0;
                        w_state   = S_PARITY;
                        w_tx_out  = r_parity;
                     end
                  end
                  S_PARITY: begin
                     w_state  = S_GUARD;
                     w_tx_out = 1'b1;
                  end
                  S_GUARD: begin
                     w_state  = S_STOP;
                     w_tx_out = 1'b1;
                  end
                  default: begin
                     // STOP done (or an illegal encoding): back to idle.
                     w_state  = S_IDLE;
                     w_tx_out = 1'b1;
                     w_busy   = 1'b0;
                  end
               endcase
            end else begin
               w_tick = r_tick + TW'(1);
            end
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: bench for uart_tx with even and odd parity instances side by
// side; hand-written frame table, corner sequences and a random phase
// compared every cycle against a frame-level reference model.
module tb_uart_tx;

   localparam int CPB   = 8;
   localparam int FRAME = 6 * CPB;

   logic       rxclk = 1'b0;
   logic       reset = 1'b0;
   logic [1:0] tx_data = 2'b00;
   logic       ld_tx_data = 1'b0;
   logic       tx_enable = 1'b0;
   logic       out_e, busy_e, ovr_e;
   logic       out_o, busy_o, ovr_o;

   always #5 rxclk = ~rxclk;

   uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b0)) dut_even (
      .rxclk(rxclk), .reset(reset), .tx_data(tx_data), .ld_tx_data(ld_tx_data),
      .tx_enable(tx_enable), .tx_out(out_e), .tx_busy(busy_e), .tx_over_run(ovr_e)
   );

   uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b1)) dut_odd (
      .rxclk(rxclk), .reset(reset), .tx_data(tx_data), .ld_tx_data(ld_tx_data),
      .tx_enable(tx_enable), .tx_out(out_o), .tx_busy(busy_o), .tx_over_run(ovr_o)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (frame level) ----------------
   int         m_cyc    = 0;   // edges since reset
   int         m_start  = 0;   // edge number of the accepting edge
   bit         m_active = 1'b0;
   bit         m_ovr    = 1'b0;
   logic [1:0] m_word   = 2'b00;

   function automatic bit model_busy();
      return m_active && ((m_cyc - m_start) < FRAME);
   endfunction

   function automatic logic frame_bit(input logic [1:0] w, input int idx, input bit odd);
      case (idx)
         0:       return 1'b0;
         1:       return w[1];
         2:       return w[0];
         3:       return w[1] ^ w[0] ^ odd;
         default: return 1'b1;
      endcase
   endfunction

   function automatic logic model_line(input bit odd);
      if (!model_busy()) return 1'b1;
      return frame_bit(m_word, (m_cyc - m_start) / CPB, odd);
   endfunction

   always @(posedge rxclk or posedge reset) begin
      if (reset) begin
         m_cyc    <= 0;
         m_active <= 1'b0;
         m_ovr    <= 1'b0;
      end else begin
         m_cyc <= m_cyc + 1;
         if (ld_tx_data && model_busy()) begin
            m_ovr <= 1'b1;
         end else if (ld_tx_data && tx_enable) begin
            m_start  <= m_cyc + 1;
            m_active <= 1'b1;
            m_word   <= tx_data;
            m_ovr    <= 1'b0;
         end
      end
   end

   bit mon_en = 1'b0;

   always @(negedge rxclk) begin
      if (mon_en && !reset) begin
         check("model_even", {29'd0, out_e, busy_e, ovr_e},
               {29'd0, model_line(1'b0), model_busy(), m_ovr});
         check("model_odd", {29'd0, out_o, busy_o, ovr_o},
               {29'd0, model_line(1'b1), model_busy(), m_ovr});
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cycles(input int n);
      repeat (n) @(negedge rxclk);
   endtask

   // One-cycle load strobe; returns just after the accepting edge.
   task automatic do_load(input logic [1:0] d, input logic en);
      tx_data    = d;
      tx_enable  = en;
      ld_tx_data = 1'b1;
      @(negedge rxclk);
      ld_tx_data = 1'b0;
      tx_data    = 2'($urandom);
   endtask

   // Called just after the accepting edge; walks the full 48-cycle frame.
   task automatic check_frame(input string tag, input logic [0:5] fe, input logic [0:5] fo);
      for (int i = 0; i < FRAME; i++) begin
         if (i % CPB == CPB / 2) begin
            check({tag, "_bit_even"}, out_e, fe[i / CPB]);
            check({tag, "_bit_odd"},  out_o, fo[i / CPB]);
         end
         if (i == 0 || i == FRAME - 1) check({tag, "_busy_hi"}, {busy_e, busy_o}, 2'b11);
         cycles(1);
      end
      check({tag, "_busy_fall"}, {busy_e, busy_o}, 2'b00);
      check({tag, "_idle_line"}, {out_e, out_o}, 2'b11);
   endtask

   typedef struct {
      logic [1:0] data;
      logic       en;
      logic [0:5] fe;
      logic [0:5] fo;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int c;
      vecs[0] = '{2'b10, 1'b1, 6'b010111, 6'b010011};
      vecs[1] = '{2'b11, 1'b1, 6'b011011, 6'b011111};
      vecs[2] = '{2'b01, 1'b1, 6'b001111, 6'b001011};
      vecs[3] = '{2'b00, 1'b1, 6'b000011, 6'b000111};
      vecs[4] = '{2'b10, 1'b0, 6'b111111, 6'b111111};
      vecs[5] = '{2'b01, 1'b1, 6'b001111, 6'b001011};

      // Reset values
      reset = 1'b1;
      cycles(2);
      check("reset_even", {out_e, busy_e, ovr_e}, 3'b100);
      check("reset_odd",  {out_o, busy_o, ovr_o}, 3'b100);
      #1 reset = 1'b0;
      mon_en = 1'b1;
      cycles(2);

      // Table-driven frames
      for (int v = 0; v < 6; v++) begin
         do_load(vecs[v].data, vecs[v].en);
         if (vecs[v].en) begin
            check_frame("table", vecs[v].fe, vecs[v].fo);
         end else begin
            for (int i = 0; i < 10; i++) begin
               if (i == 0 || i == 9) begin
                  check("disabled_line", {out_e, out_o}, 2'b11);
                  check("disabled_busy", {busy_e, busy_o, ovr_e}, 3'b000);
               end
               cycles(1);
            end
         end
         cycles(2);
      end

      // Overrun: load 01, second load at cycle 20 is dropped
      do_load(2'b01, 1'b1);
      cycles(19);
      tx_data = 2'b10;
      ld_tx_data = 1'b1;
      cycles(1);
      ld_tx_data = 1'b0;
      check("ovr_set", {ovr_e, ovr_o}, 2'b11);
      check("ovr_word_d0", out_e, 1'b1);
      cycles(8);
      check("ovr_word_par_even", out_e, 1'b1);
      check("ovr_word_par_odd",  out_o, 1'b0);
      cycles(FRAME - 28);
      check("ovr_frame_end", {busy_e, ovr_e, ovr_o}, 3'b011);
      cycles(2);
      do_load(2'b11, 1'b1);
      check("ovr_cleared", {ovr_e, ovr_o, busy_e}, 3'b001);
      cycles(FRAME + 2);

      // tx_enable dropped mid-frame
      do_load(2'b11, 1'b1);
      for (int i = 1; i < FRAME; i++) begin
         cycles(1);
         if (i == 10) tx_enable = 1'b0;
      end
      check("en_drop_busy47", busy_e, 1'b1);
      cycles(1);
      check("en_drop_busy48", busy_e, 1'b0);
      cycles(2);
      tx_enable = 1'b1;

      // Asynchronous reset mid-frame
      do_load(2'b10, 1'b1);
      cycles(24);
      #1 reset = 1'b1;
      #1;
      check("async_rst_even", {out_e, busy_e, ovr_e}, 3'b100);
      check("async_rst_odd",  {out_o, busy_o, ovr_o}, 3'b100);
      cycles(2);
      #1 reset = 1'b0;
      cycles(5);
      check("post_rst_idle", {out_e, busy_e}, 2'b10);
      do_load(2'b00, 1'b1);
      check_frame("post_rst", 6'b000011, 6'b000111);
      cycles(2);

      // Load held high with changing data: frames every 49 cycles
      tx_enable  = 1'b1;
      tx_data    = 2'($urandom);
      ld_tx_data = 1'b1;
      c = 0;
      while (!busy_e && c < 10) begin
         cycles(1);
         tx_data = tx_data ^ 2'($urandom_range(1, 3));
         c++;
      end
      check("held_first_start", busy_e, 1'b1);
      for (int f = 0; f < 3; f++) begin
         c = 0;
         while (busy_e && c < 100) begin
            cycles(1);
            tx_data = tx_data ^ 2'($urandom_range(1, 3));
            c++;
         end
         check("held_busy_len", c, FRAME);
         c = 0;
         while (!busy_e && c < 10) begin
            cycles(1);
            tx_data = tx_data ^ 2'($urandom_range(1, 3));
            c++;
         end
         check("held_gap", c, 1);
      end
      ld_tx_data = 1'b0;
      c = 0;
      while (busy_e && c < 100) begin
         cycles(1);
         c++;
      end
      check("held_drain", busy_e, 1'b0);

      // Random phase, checked each cycle against the model
      for (int i = 0; i < 1500; i++) begin
         ld_tx_data = ($urandom_range(0, 9) == 0);
         tx_enable  = ($urandom_range(0, 3) != 0);
         tx_data    = 2'($urandom);
         if ($urandom_range(0, 299) == 0) begin
            #1 reset = 1'b1;
            #1 reset = 1'b0;
         end
         cycles(1);
      end
      ld_tx_data = 1'b0;
      cycles(FRAME + 2);

      mon_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
